// File: rtl/easyaxi_pkg.sv
// Shared definitions for the EasyAXI slot queue: slot state encodings,
// default queue depth and a width helper.
package easyaxi_pkg;

   typedef enum logic [1:0] {
      SLOT_FREE   = 2'd0,
      SLOT_PEND   = 2'd1,
      SLOT_ISSUED = 2'd2
   } slot_state_e;

   localparam int DEEP_NUM_DEF = 8;

   // Ceiling log2, never less than 1 so a single-slot queue still has an index bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/easyaxi_onehot2bin.sv
// One-hot to binary encoder. An all-zero input encodes to 0; callers qualify
// the result with their own valid bit.
module easyaxi_onehot2bin
   import easyaxi_pkg::*;
#(
   parameter int DEEP_NUM = DEEP_NUM_DEF,
   parameter int ID_WIDTH = clog2(DEEP_NUM)
) (
   input  logic [DEEP_NUM-1:0] onehot,
   output logic [ID_WIDTH-1:0] bin
);

   // OR together the indices of all set bits; exact for one-hot input.
   always_comb begin
      bin = '0;
      for (int i = 0; i < DEEP_NUM; i++) begin
         if (onehot[i]) begin
            bin = bin | i[ID_WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/easyaxi_slot_queue.sv
// Transaction slot manager feeding the EasyAXI round-robin arbiter.
// Slots move FREE -> PEND (alloc) -> ISSUED (dispatch) -> FREE (done).
module easyaxi_slot_queue
   import easyaxi_pkg::*;
#(
   parameter int DEEP_NUM = DEEP_NUM_DEF,
   parameter int ID_WIDTH = clog2(DEEP_NUM)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                alloc_valid,
   output logic                alloc_ready,
   output logic [ID_WIDTH-1:0] alloc_id,
   output logic [DEEP_NUM-1:0] queue_o,
   output logic                sche_en_o,
   input  logic [DEEP_NUM-1:0] pointer_i,
   output logic                dispatch_valid,
   output logic [ID_WIDTH-1:0] dispatch_id,
   input  logic                dispatch_ready,
   input  logic                done_valid,
   input  logic [ID_WIDTH-1:0] done_id,
   output logic                done_err,
   output logic [ID_WIDTH:0]   count,
   output logic                full,
   output logic                empty
);

   slot_state_e         slot_q [DEEP_NUM];
   logic [DEEP_NUM-1:0] pend_bits;
   logic [DEEP_NUM-1:0] issued_bits;
   logic [DEEP_NUM-1:0] free_bits;
   logic [DEEP_NUM-1:0] free_lowest;
   logic [DEEP_NUM-1:0] sel;
   logic                alloc_fire;
   logic                dispatch_fire;
   logic                done_hit;

   // Decode per-slot state; the illegal encoding falls into neither set and so counts as FREE.
   always_comb begin
      pend_bits   = '0;
      issued_bits = '0;
      count       = '0;
      for (int i = 0; i < DEEP_NUM; i++) begin
         pend_bits[i]   = (slot_q[i] == SLOT_PEND);
         issued_bits[i] = (slot_q[i] == SLOT_ISSUED);
         count          = count + {{ID_WIDTH{1'b0}}, pend_bits[i] | issued_bits[i]};
      end
   end

   assign free_bits   = ~(pend_bits | issued_bits);
   assign free_lowest = free_bits & (-free_bits);
   assign full        = ~(|free_bits);
   assign empty       = &free_bits;
   assign alloc_ready = ~full;
   assign alloc_fire  = alloc_valid & alloc_ready;

   assign sel            = pointer_i & pend_bits;
   assign dispatch_valid = |sel;
   assign dispatch_fire  = dispatch_valid & dispatch_ready;
   assign sche_en_o      = ~dispatch_valid | dispatch_ready;
   assign queue_o        = pend_bits & ~(pointer_i & {DEEP_NUM{dispatch_fire}});

   assign done_hit = done_valid && (int'(done_id) < DEEP_NUM) && issued_bits[done_id];

   easyaxi_onehot2bin #(.DEEP_NUM(DEEP_NUM), .ID_WIDTH(ID_WIDTH)) u_alloc_enc (
      .onehot (free_lowest),
      .bin    (alloc_id)
   );

   easyaxi_onehot2bin #(.DEEP_NUM(DEEP_NUM), .ID_WIDTH(ID_WIDTH)) u_dispatch_enc (
      .onehot (sel),
      .bin    (dispatch_id)
   );

   // Slot state transitions; alloc, dispatch and done always target different slots in a cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEEP_NUM; i++) begin
            slot_q[i] <= SLOT_FREE;
         end
         done_err <= 1'b0;
      end else begin
         done_err <= done_valid & ~done_hit;
         for (int i = 0; i < DEEP_NUM; i++) begin
            if (alloc_fire && free_lowest[i]) begin
               slot_q[i] <= SLOT_PEND;
            end else if (dispatch_fire && sel[i]) begin
               slot_q[i] <= SLOT_ISSUED;
            end else if (done_hit && (int'(done_id) == i)) begin
               slot_q[i] <= SLOT_FREE;
            end else if (!(pend_bits[i] || issued_bits[i])) begin
               slot_q[i] <= SLOT_FREE;
            end
         end
      end
   end

   a_pointer_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(pointer_i));

   a_dispatch_stable : assert property (@(posedge clk) disable iff (rst)
      (dispatch_valid && !dispatch_ready) |=> (dispatch_valid && $stable(dispatch_id)));

   for (genvar g = 0; g < DEEP_NUM; g++) begin : g_slot_chk
      a_slot_legal : assert property (@(posedge clk) disable iff (rst)
         (pend_bits[g] || issued_bits[g] || (slot_q[g] == SLOT_FREE)));
   end

endmodule

// File: tb/tb_easyaxi_slot_queue.sv
// Directed bench for easyaxi_slot_queue with a behavioural round-robin arbiter.
module tb_easyaxi_slot_queue;

   logic       clk;
   logic       rst;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [2:0] alloc_id;
   logic [7:0] queue_o;
   logic       sche_en_o;
   logic [7:0] pointer_i;
   logic       dispatch_valid;
   logic [2:0] dispatch_id;
   logic       dispatch_ready;
   logic       done_valid;
   logic [2:0] done_id;
   logic       done_err;
   logic [3:0] count;
   logic       full;
   logic       empty;

   int total;
   int bad;
   int arb_last;
   int arb_next;

   easyaxi_slot_queue #(.DEEP_NUM(8), .ID_WIDTH(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_id       (alloc_id),
      .queue_o        (queue_o),
      .sche_en_o      (sche_en_o),
      .pointer_i      (pointer_i),
      .dispatch_valid (dispatch_valid),
      .dispatch_id    (dispatch_id),
      .dispatch_ready (dispatch_ready),
      .done_valid     (done_valid),
      .done_id        (done_id),
      .done_err       (done_err),
      .count          (count),
      .full           (full),
      .empty          (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-robin pick starting just after the last granted index; -1 when nothing requests.
   function automatic int rr_index(input logic [7:0] q, input int last);
      for (int k = 1; k <= 8; k++) begin
         int idx;
         idx = (last + k) % 8;
         if (q[idx]) return idx;
      end
      return -1;
   endfunction

   // Arbiter stand-in: registered one-hot grant, frozen while sche_en is low.
   always_comb arb_next = rr_index(queue_o, arb_last);

   // Arbiter grant register.
   always @(posedge clk) begin
      if (rst) begin
         pointer_i <= 8'h00;
         arb_last  <= 7;
      end else if (sche_en_o) begin
         pointer_i <= (arb_next >= 0) ? 8'(1 << arb_next) : 8'h00;
         if (arb_next >= 0) arb_last <= arb_next;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; alloc_valid = 1'b0; dispatch_ready = 1'b0; done_valid = 1'b0; done_id = 3'd0;
      cycle(); cycle();
      rst = 1'b0;
      #1;
      total++; if (queue_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_queue actual=%h required=%h", queue_o, 8'h00); end
      total++; if (dispatch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dvalid actual=%b required=0", dispatch_valid); end
      total++; if (sche_en_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_sche_en actual=%b required=1", sche_en_o); end
      total++; if (alloc_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_aready actual=%b required=1", alloc_ready); end
      total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count actual=%0d required=0", count); end
      total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags actual=%b%b required=10", empty, full); end
      total++; if (done_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_done_err actual=%b required=0", done_err); end
      total++; if (alloc_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_alloc_id actual=%0d required=0", alloc_id); end
   endtask

   task automatic test_alloc();
      dispatch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1;
         #1;
         total++; if (alloc_id !== 3'(i)) begin bad++; $display("[TB] FAIL alloc_id actual=%0d required=%0d", alloc_id, i); end
         cycle();
      end
      alloc_valid = 1'b0;
      #1;
      total++; if (queue_o !== 8'h07) begin bad++; $display("[TB] FAIL alloc_queue actual=%h required=07", queue_o); end
      total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL alloc_count actual=%0d required=3", count); end
      total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'd0 || sche_en_o !== 1'b0) begin
         bad++; $display("[TB] FAIL alloc_stall actual=%b/%0d/%b required=1/0/0", dispatch_valid, dispatch_id, sche_en_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q [3];
      exp_q[0] = 8'h06; exp_q[1] = 8'h04; exp_q[2] = 8'h00;
      dispatch_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'(i)) begin
            bad++; $display("[TB] FAIL b2b_dispatch actual=%b/%0d required=1/%0d", dispatch_valid, dispatch_id, i); end
         total++; if (queue_o !== exp_q[i]) begin bad++; $display("[TB] FAIL b2b_queue actual=%h required=%h", queue_o, exp_q[i]); end
         total++; if (count !== 4'd3) begin bad++; $display("[TB] FAIL b2b_count actual=%0d required=3", count); end
         cycle();
      end
      #1;
      total++; if (dispatch_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain actual=%b required=0", dispatch_valid); end
   endtask

   task automatic test_full();
      alloc_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++; if (alloc_id !== 3'(3 + i)) begin bad++; $display("[TB] FAIL fill_id actual=%0d required=%0d", alloc_id, 3 + i); end
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (alloc_ready !== 1'b0 || full !== 1'b1 || count !== 4'd8) begin
            bad++; $display("[TB] FAIL full_hold actual=%b/%b/%0d required=0/1/8", alloc_ready, full, count); end
         cycle();
      end
      alloc_valid = 1'b0;
      done_valid = 1'b1; done_id = 3'd5;
      #1;
      cycle();
      done_valid = 1'b0;
      #1;
      total++; if (alloc_ready !== 1'b1 || alloc_id !== 3'd5 || count !== 4'd7) begin
         bad++; $display("[TB] FAIL free_reuse actual=%b/%0d/%0d required=1/5/7", alloc_ready, alloc_id, count); end
      total++; if (done_err !== 1'b0 || full !== 1'b0) begin bad++; $display("[TB] FAIL free_flags actual=%b/%b required=0/0", done_err, full); end
   endtask

   task automatic test_stall();
      dispatch_ready = 1'b0;
      done_valid = 1'b1; done_id = 3'd0;
      #1; cycle();
      done_id = 3'd1;
      #1; cycle();
      done_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         alloc_valid = 1'b1;
         #1;
         total++; if (alloc_id !== 3'(i)) begin bad++; $display("[TB] FAIL stall_alloc_id actual=%0d required=%0d", alloc_id, i); end
         cycle();
      end
      alloc_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'd0 || sche_en_o !== 1'b0) begin
            bad++; $display("[TB] FAIL stall_hold actual=%b/%0d/%b required=1/0/0", dispatch_valid, dispatch_id, sche_en_o); end
         cycle();
      end
      dispatch_ready = 1'b1;
      #1;
      total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'd0) begin
         bad++; $display("[TB] FAIL stall_release actual=%b/%0d required=1/0", dispatch_valid, dispatch_id); end
      cycle();
      #1;
      total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'd1) begin
         bad++; $display("[TB] FAIL stall_next actual=%b/%0d required=1/1", dispatch_valid, dispatch_id); end
      cycle();
      dispatch_ready = 1'b0;
      #1;
      total++; if (dispatch_valid !== 1'b0 || count !== 4'd7) begin
         bad++; $display("[TB] FAIL stall_end actual=%b/%0d required=0/7", dispatch_valid, count); end
   endtask

   task automatic test_done_err();
      alloc_valid = 1'b1;
      #1;
      total++; if (alloc_id !== 3'd5) begin bad++; $display("[TB] FAIL derr_alloc_id actual=%0d required=5", alloc_id); end
      cycle();
      alloc_valid = 1'b0;
      done_valid = 1'b1; done_id = 3'd5;
      #1;
      cycle();
      done_valid = 1'b0;
      #1;
      total++; if (done_err !== 1'b1) begin bad++; $display("[TB] FAIL derr_pulse actual=%b required=1", done_err); end
      total++; if (count !== 4'd8 || queue_o !== 8'h20) begin bad++; $display("[TB] FAIL derr_state actual=%0d/%h required=8/20", count, queue_o); end
      total++; if (dispatch_valid !== 1'b1 || dispatch_id !== 3'd5) begin
         bad++; $display("[TB] FAIL derr_dispatch actual=%b/%0d required=1/5", dispatch_valid, dispatch_id); end
      cycle();
      #1;
      total++; if (done_err !== 1'b0 || queue_o !== 8'h20) begin bad++; $display("[TB] FAIL derr_clear actual=%b/%h required=0/20", done_err, queue_o); end
   endtask

   task automatic test_reset_mid();
      done_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         done_id = 3'(i);
         #1;
         cycle();
      end
      done_id = 3'd0;
      #1;
      cycle();
      done_valid = 1'b0;
      #1;
      total++; if (done_err !== 1'b1 || count !== 4'd4) begin bad++; $display("[TB] FAIL free_done_err actual=%b/%0d required=1/4", done_err, count); end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      total++; if (queue_o !== 8'h00 || dispatch_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_mid_q actual=%h/%b required=00/0", queue_o, dispatch_valid); end
      total++; if (count !== 4'd0 || empty !== 1'b1 || alloc_id !== 3'd0) begin
         bad++; $display("[TB] FAIL rst_mid_state actual=%0d/%b/%0d required=0/1/0", count, empty, alloc_id); end
      total++; if (done_err !== 1'b0 || sche_en_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_misc actual=%b/%b required=0/1", done_err, sche_en_o); end
   endtask

   // Scenario sequence; each task leaves the queue in the state the next one expects.
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_alloc();
      test_back_to_back();
      test_full();
      test_stall();
      test_done_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
